// File: rtl/uart_word_link.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_word_link                                               |
// | Description : 8N1 UART transceiver that moves 1..WORD_BYTES-byte words.    |
// |               TX serialises a word MSB-byte first behind valid/ready;      |
// |               RX deserialises bytes, flags bad stop bits and reassembles   |
// |               full words (first byte received lands in the MS byte).       |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               tx_valid/tx_ready handshake, tx_data word, tx_len byte count |
// |               tx_pin_out serial out (idles high), rx_pin_in serial in      |
// |               rx_byte/rx_byte_valid, rx_word/rx_word_valid, rx_frame_err   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_word_link #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_BYTES   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    input  logic [8*WORD_BYTES-1:0]        tx_data,
    input  logic [$clog2(WORD_BYTES+1)-1:0] tx_len,
    output logic                           tx_pin_out,
    input  logic                           rx_pin_in,
    output logic [7:0]                     rx_byte,
    output logic                           rx_byte_valid,
    output logic [8*WORD_BYTES-1:0]        rx_word,
    output logic                           rx_word_valid,
    output logic                           rx_frame_err
);

    localparam int c_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int c_LEN_W  = $clog2(WORD_BYTES + 1);
    localparam int c_WORD_W = 8 * WORD_BYTES;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_LEN_W-1:0] c_WB        = c_LEN_W'(WORD_BYTES);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_STOP} rx_state_t;

    // ------------------------------------------------------------------ TX
    tx_state_t            r_tx_state, w_tx_state_nxt;
    logic [c_CNT_W-1:0]   r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]           r_tx_bit, w_tx_bit_nxt;
    logic [c_LEN_W-1:0]   r_tx_left, w_tx_left_nxt;
    logic [c_WORD_W-1:0]  r_tx_word, w_tx_word_nxt;
    logic                 r_tx_pin, r_tx_ready;
    logic                 w_tx_accept, w_tx_pin_nxt;
    logic [c_LEN_W-1:0]   w_tx_len_clamped;
    logic [7:0]           w_tx_byte_nxt;

    assign w_tx_accept      = tx_valid && r_tx_ready;
    assign w_tx_len_clamped = (tx_len > c_WB) ? c_WB : tx_len;
    // The byte on the wire is always the top byte of the (shifting) word.
    assign w_tx_byte_nxt    = w_tx_word_nxt[c_WORD_W-1 -: 8];

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_left_nxt  = r_tx_left;
        w_tx_word_nxt  = r_tx_word;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_tx_accept) begin
                    w_tx_word_nxt = tx_data;
                    w_tx_left_nxt = w_tx_len_clamped;
                    w_tx_cnt_nxt  = '0;
                    if (w_tx_len_clamped != '0) begin
                        w_tx_state_nxt = TX_START;
                    end
                end
            end
            TX_START: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_state_nxt = TX_DATA;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_left_nxt  = r_tx_left - 1'b1;
                    w_tx_word_nxt  = r_tx_word << 8;
                    w_tx_state_nxt = (r_tx_left == c_LEN_W'(1)) ? TX_IDLE : TX_START;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // Line level is computed from the next state so the pin is a flop output
    // yet changes in the same cycle the state does.
    always_comb begin
        w_tx_pin_nxt = 1'b1;
        case (w_tx_state_nxt)
            TX_START: w_tx_pin_nxt = 1'b0;
            TX_DATA:  w_tx_pin_nxt = w_tx_byte_nxt[w_tx_bit_nxt];
            default:  w_tx_pin_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_left  <= '0;
            r_tx_word  <= '0;
            r_tx_pin   <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_left  <= w_tx_left_nxt;
            r_tx_word  <= w_tx_word_nxt;
            r_tx_pin   <= w_tx_pin_nxt;
            // A zero-length word still drops ready for one cycle.
            r_tx_ready <= (w_tx_state_nxt == TX_IDLE) && !w_tx_accept;
        end
    end

    assign tx_pin_out = r_tx_pin;
    assign tx_ready   = r_tx_ready;

    // ------------------------------------------------------------------ RX
    logic [1:0]           r_rx_sync;
    logic                 r_rx_prev;
    rx_state_t            r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0]   r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]           r_rx_bit, w_rx_bit_nxt;
    logic [7:0]           r_rx_shift, w_rx_shift_nxt;
    logic [c_LEN_W-1:0]   r_rx_num, w_rx_num_nxt;
    logic [c_WORD_W-1:0]  w_rx_asm_full;
    logic                 w_rx_line, w_rx_fall;
    logic                 w_rx_good, w_rx_err, w_rx_word_done;
    logic [7:0]           r_rx_byte;
    logic [c_WORD_W-1:0]  r_rx_word;
    logic                 r_rx_byte_valid, r_rx_word_valid, r_rx_frame_err;

    assign w_rx_line = r_rx_sync[1];
    assign w_rx_fall = r_rx_prev && !w_rx_line;

    // Assembler holds the bytes already received; the newest byte is appended
    // at the bottom so the first byte of a word ends up most significant.
    generate
        if (WORD_BYTES == 1) begin : g_asm_single
            assign w_rx_asm_full = r_rx_shift;
        end else begin : g_asm_multi
            logic [c_WORD_W-9:0] r_rx_asm;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rx_asm <= '0;
                end else if (w_rx_good) begin
                    r_rx_asm <= w_rx_asm_full[c_WORD_W-9:0];
                end
            end
            assign w_rx_asm_full = {r_rx_asm, r_rx_shift};
        end
    endgenerate

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_num_nxt   = r_rx_num;
        w_rx_good      = 1'b0;
        w_rx_err       = 1'b0;
        w_rx_word_done = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_START_CHK;
                end
            end
            RX_START_CHK: begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = 3'd0;
                    // Line back high at mid-start means a glitch, not a frame.
                    w_rx_state_nxt = w_rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {w_rx_line, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_IDLE;
                    if (w_rx_line) begin
                        w_rx_good = 1'b1;
                        if (r_rx_num == c_WB - 1'b1) begin
                            w_rx_word_done = 1'b1;
                            w_rx_num_nxt   = '0;
                        end else begin
                            w_rx_num_nxt = r_rx_num + 1'b1;
                        end
                    end else begin
                        w_rx_err     = 1'b1;
                        w_rx_num_nxt = '0;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync       <= 2'b11;
            r_rx_prev       <= 1'b1;
            r_rx_state      <= RX_IDLE;
            r_rx_cnt        <= '0;
            r_rx_bit        <= 3'd0;
            r_rx_shift      <= 8'd0;
            r_rx_num        <= '0;
            r_rx_byte       <= 8'd0;
            r_rx_word       <= '0;
            r_rx_byte_valid <= 1'b0;
            r_rx_word_valid <= 1'b0;
            r_rx_frame_err  <= 1'b0;
        end else begin
            r_rx_sync       <= {r_rx_sync[0], rx_pin_in};
            r_rx_prev       <= w_rx_line;
            r_rx_state      <= w_rx_state_nxt;
            r_rx_cnt        <= w_rx_cnt_nxt;
            r_rx_bit        <= w_rx_bit_nxt;
            r_rx_shift      <= w_rx_shift_nxt;
            r_rx_num        <= w_rx_num_nxt;
            r_rx_byte_valid <= w_rx_good;
            r_rx_word_valid <= w_rx_word_done;
            r_rx_frame_err  <= w_rx_err;
            if (w_rx_good) begin
                r_rx_byte <= r_rx_shift;
            end
            if (w_rx_word_done) begin
                r_rx_word <= w_rx_asm_full;
            end
        end
    end

    assign rx_byte       = r_rx_byte;
    assign rx_byte_valid = r_rx_byte_valid;
    assign rx_word       = r_rx_word;
    assign rx_word_valid = r_rx_word_valid;
    assign rx_frame_err  = r_rx_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_link.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_word_link                                            |
// | Description : Directed self-checking bench for uart_word_link with         |
// |               CLKS_PER_BIT=16, WORD_BYTES=4.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_word_link;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] tx_data = 32'd0;
    logic [2:0]  tx_len = 3'd0;
    logic        tx_pin_out;
    logic        rx_line;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [31:0] rx_word;
    logic        rx_word_valid;
    logic        rx_frame_err;
    logic        stim = 1'b1;
    logic        lb = 1'b0;

    int n_vec = 0;
    int n_miss = 0;
    logic [7:0]  bq[$];
    logic [31:0] wq[$];
    int n_ferr = 0;
    int n_wnc = 0;

    assign rx_line = lb ? tx_pin_out : stim;

    always #5 clk = ~clk;

    uart_word_link #(.CLKS_PER_BIT(16), .WORD_BYTES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_len       (tx_len),
        .tx_pin_out   (tx_pin_out),
        .rx_pin_in    (rx_line),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .rx_word      (rx_word),
        .rx_word_valid(rx_word_valid),
        .rx_frame_err (rx_frame_err)
    );

    // RX pulse monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_byte_valid) bq.push_back(rx_byte);
            if (rx_word_valid) begin
                wq.push_back(rx_word);
                if (!rx_byte_valid) n_wnc++;
            end
            if (rx_frame_err) n_ferr++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rx();
        bq.delete();
        wq.delete();
        n_ferr = 0;
        n_wnc  = 0;
    endtask

    // Sends one word, records the line for its full duration and checks each
    // frame bit by bit (every cycle of a bit must match its mid-bit level).
    task automatic tx_word(input logic [31:0] d, input logic [2:0] len, input int nb);
        int   w;
        int   bad;
        logic smp[0:639];
        logic rdy_last;
        logic [9:0] obs;
        w = 0;
        while (!tx_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("tx_ready_wait", tx_ready, 1);
        tx_data  = d;
        tx_len   = len;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
        tx_len   = 3'd1;
        rdy_last = 1'b1;
        for (int i = 0; i < nb * 160; i++) begin
            @(negedge clk);
            smp[i] = tx_pin_out;
            if (i == 0) check("tx_ready_busy", tx_ready, 0);
            rdy_last = tx_ready;
        end
        @(negedge clk);
        check("tx_ready_last", rdy_last, 0);
        check("tx_ready_done", tx_ready, 1);
        check("tx_idle_line", tx_pin_out, 1);
        bad = 0;
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < 10; k++) begin
                obs[k] = smp[(10 * j + k) * 16 + 8];
                for (int c = 0; c < 16; c++) begin
                    if (smp[(10 * j + k) * 16 + c] !== obs[k]) bad++;
                end
            end
            check("tx_frame", obs, {1'b1, d[31 - 8 * j -: 8], 1'b0});
        end
        check("tx_bitexact", bad, 0);
    endtask

    // Drives one 8N1 frame; x2 is twice the bit period so half-cycle bauds work.
    task automatic rx_send(input logic [7:0] b, input logic stp, input int x2, input int idle);
        logic [9:0] fr;
        fr = {stp, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            stim = fr[k];
            repeat (((k + 1) * x2 + 1) / 2 - (k * x2 + 1) / 2) @(negedge clk);
        end
        stim = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic rx_send_word(input logic [31:0] w, input int x2);
        for (int i = 0; i < 4; i++) rx_send(w[31 - 8 * i -: 8], 1'b1, x2, 4);
    endtask

    task automatic check_rx_word(input logic [31:0] w);
        check("rx_nbytes", bq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("rx_byte_seq", (i < bq.size()) ? bq[i] : 8'hxx, w[31 - 8 * i -: 8]);
        end
        check("rx_nwords", wq.size(), 1);
        check("rx_word_val", (wq.size() > 0) ? wq[0] : 32'hxxxxxxxx, w);
        check("rx_word_coinc", n_wnc, 0);
        check("rx_no_ferr", n_ferr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lows;
        // 1. reset state, then reset mid-frame
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx_pin", tx_pin_out, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_rx_word", rx_word, 0);
        check("rst_pulses", {rx_byte_valid, rx_word_valid, rx_frame_err}, 0);

        tx_data  = 32'hA1B2C3D4;
        tx_len   = 3'd4;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("pre_rst_pin", tx_pin_out, 0);
        check("pre_rst_ready", tx_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pin", tx_pin_out, 1);
        check("async_rst_ready", tx_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rx", {rx_byte, rx_word, rx_byte_valid, rx_word_valid, rx_frame_err}, 0);

        // 2. full word, then back-to-back clamped length (7 -> 4 bytes)
        tx_word(32'hA1B2C3D4, 3'd4, 4);
        tx_word(32'h0BADF00D, 3'd7, 4);

        // 3. single byte and zero-length word
        tx_word(32'h55E71234, 3'd1, 1);
        tx_len   = 3'd0;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        check("len0_ready_low", tx_ready, 0);
        check("len0_pin", tx_pin_out, 1);
        @(negedge clk);
        check("len0_ready_back", tx_ready, 1);
        lows = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!tx_pin_out) lows++;
        end
        check("len0_idle_line", lows, 0);

        // 4. loopback word
        clear_rx();
        lb = 1'b1;
        tx_word(32'hDEADBEEF, 3'd4, 4);
        repeat (20) @(negedge clk);
        check_rx_word(32'hDEADBEEF);
        lb = 1'b0;

        // 5. framing error, recovery, glitch
        clear_rx();
        rx_send(8'h11, 1'b1, 32, 4);
        rx_send(8'h22, 1'b1, 32, 4);
        rx_send(8'h33, 1'b0, 32, 16);
        check("ferr_byte_hold", rx_byte, 8'h22);
        rx_send_word(32'h01020304, 32);
        repeat (20) @(negedge clk);
        check("ferr_count", n_ferr, 1);
        check("ferr_nbytes", bq.size(), 6);
        check("ferr_b0", (bq.size() > 0) ? bq[0] : 8'hxx, 8'h11);
        check("ferr_b1", (bq.size() > 1) ? bq[1] : 8'hxx, 8'h22);
        check("ferr_b2", (bq.size() > 2) ? bq[2] : 8'hxx, 8'h01);
        check("ferr_b5", (bq.size() > 5) ? bq[5] : 8'hxx, 8'h04);
        check("ferr_nwords", wq.size(), 1);
        check("ferr_word", (wq.size() > 0) ? wq[0] : 32'hxxxxxxxx, 32'h01020304);

        clear_rx();
        stim = 1'b0;
        repeat (4) @(negedge clk);
        stim = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_pulses", bq.size() + wq.size() + n_ferr, 0);

        // 6. full duplex with skewed RX baud
        clear_rx();
        fork
            tx_word(32'h0F1E2D3C, 3'd4, 4);
            rx_send_word(32'h3CA5817E, 31);
        join
        repeat (20) @(negedge clk);
        check_rx_word(32'h3CA5817E);

        clear_rx();
        fork
            tx_word(32'hC3965A69, 3'd4, 4);
            rx_send_word(32'h00FF8001, 33);
        join
        repeat (20) @(negedge clk);
        check_rx_word(32'h00FF8001);

        // stress bauds: only the TX line is judged here
        fork
            tx_word(32'h12345678, 3'd4, 4);
            begin
                rx_send(8'hFF, 1'b1, 30, 4);
                rx_send(8'hC3, 1'b1, 30, 4);
                rx_send(8'hA5, 1'b1, 34, 4);
                rx_send(8'h5A, 1'b1, 34, 4);
            end
        join
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
